// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM encoding and sizing helpers
// for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RELEASE  = 3'd1,
    WAIT_RDY = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_e;

  function automatic int cnt_width(
    input int hold,
    input int gap,
    input int tmo
  );
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync: 2-flop synchroniser, asynchronous assert
// and synchronous deassert of an active-low reset.
module reset_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_no = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases per-subsystem resets in order, waiting for each
// stage's ready acknowledge with a timeout; reports completion or the failing stage.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int HOLD_CYC  = 1024,
  parameter int STAGE_GAP = 256,
  parameter int TIMEOUT   = 65535,
  parameter int SW        = idx_width(STAGES)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ResetReq,
  input  logic [STAGES-1:0] StageReady,
  output logic [STAGES-1:0] StageReset,
  output logic              AllReady,
  output logic              Busy,
  output logic              Fault,
  output logic [SW-1:0]     FaultStage
);

  localparam int CW = cnt_width(HOLD_CYC, STAGE_GAP, TIMEOUT);

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TMO_END  = CW'(TIMEOUT);
  localparam logic [SW-1:0] LAST     = SW'(STAGES - 1);

  logic rst_s_n;

  reset_sync u_rst_sync (
    .clk_i  (Clock),
    .rst_ni (Reset_n),
    .rst_no (rst_s_n)
  );

  state_e            state_q;
  logic [SW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q;
  logic [STAGES-1:0] stage_rst_q;
  logic              all_rdy_q;
  logic              busy_q;
  logic              fault_q;
  logic [SW-1:0]     fstage_q;

  logic              drop_any;
  logic [SW-1:0]     drop_idx;

  // Scanning downward leaves the lowest dropped index.
  always_comb begin
    drop_any = 1'b0;
    drop_idx = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!StageReady[i]) begin
        drop_any = 1'b1;
        drop_idx = SW'(i);
      end
    end
  end

  always_ff @(posedge Clock or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q     <= HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_rst_q <= '1;
      all_rdy_q   <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      fstage_q    <= '0;
    end else if (ResetReq) begin
      state_q     <= HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_rst_q <= '1;
      all_rdy_q   <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      fstage_q    <= '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_END) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          stage_rst_q[idx_q] <= 1'b0;
          cnt_q              <= '0;
          state_q            <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (StageReady[idx_q]) begin
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (cnt_q == TMO_END) begin
            state_q  <= FAULT;
            busy_q   <= 1'b0;
            fault_q  <= 1'b1;
            fstage_q <= idx_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_END) begin
            cnt_q <= '0;
            if (idx_q == LAST) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              all_rdy_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + SW'(1);
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (drop_any) begin
            state_q   <= FAULT;
            all_rdy_q <= 1'b0;
            fault_q   <= 1'b1;
            fstage_q  <= drop_idx;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign StageReset = stage_rst_q;
  assign AllReady   = all_rdy_q;
  assign Busy       = busy_q;
  assign Fault      = fault_q;
  assign FaultStage = fstage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized runs against a timeline model;
// expected output changes are queued and checked by a monitor.
module tb_reset_sequencer;

  localparam int STG = 3;
  localparam int HC  = 8;
  localparam int SG  = 4;
  localparam int TO  = 20;
  localparam int BIG = 1 << 30;
  localparam logic [7:0] RSTV = 8'b111_010_00;

  logic           Clock = 1'b0;
  logic           Reset_n = 1'b1;
  logic           ResetReq = 1'b0;
  logic [STG-1:0] StageReady = '0;
  logic [STG-1:0] StageReset;
  logic           AllReady;
  logic           Busy;
  logic           Fault;
  logic [1:0]     FaultStage;

  reset_sequencer #(
    .STAGES    (STG),
    .HOLD_CYC  (HC),
    .STAGE_GAP (SG),
    .TIMEOUT   (TO)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ResetReq   (ResetReq),
    .StageReady (StageReady),
    .StageReset (StageReset),
    .AllReady   (AllReady),
    .Busy       (Busy),
    .Fault      (Fault),
    .FaultStage (FaultStage)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] cur = RSTV;
  int         lim = BIG;
  int         rise[STG];
  int         drop[STG];
  int         d_pl[STG];
  int         rr_until = 0;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [7:0] outv();
    return {StageReset, AllReady, Busy, Fault, FaultStage};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_cycle();
    ResetReq = (cyc < rr_until);
    for (int i = 0; i < STG; i++)
      StageReady[i] = (cyc >= rise[i]) && (cyc < drop[i]);
  endtask

  task automatic expect_at(input int c, input logic [7:0] v);
    if (c <= lim && v !== cur) begin
      exp_q.push_back('{c, v});
      cur = v;
    end
  endtask

  // nk: 0 free choice, 1 next run must start with ResetReq now, 2 with Reset_n now
  task automatic run(input bit por, input int rrl, input int mode,
                     input int kk, input int dmask, output int nk);
    int c, s, r, e, x, fin, fstg, nrel, dd, low;
    int rel[STG];
    int rdy[STG];
    bit flt;
    logic [2:0] sr;
    c = cyc;
    nk = 0;
    flt = 0;
    fstg = 0;
    nrel = 0;
    fin = 0;
    x = BIG;
    lim = BIG;
    for (int i = 0; i < STG; i++) begin
      rise[i] = (d_pl[i] < 0) ? c : BIG;
      drop[i] = BIG;
      rel[i] = 0;
      rdy[i] = 0;
    end
    if (por) begin
      expect_at(c, RSTV);
      rr_until = 0;
      Reset_n = 1'b0;
      drive_cycle();
      #1;
      checks++;
      if (outv() !== RSTV) begin
        errors++;
        $display("FAIL async_reset got=%b want=%b", outv(), RSTV);
      end
      tick();
      Reset_n = 1'b1;
      s = c + 3;
    end else begin
      rr_until = c + rrl;
      expect_at(c + 1, RSTV);
      s = c + rrl;
    end
    r = s + HC + 1;
    for (int i = 0; i < STG; i++) begin
      if (!flt) begin
        rel[i] = r;
        nrel = i + 1;
        if (d_pl[i] > TO) begin
          flt = 1;
          fstg = i;
          fin = r + TO + 1;
        end else begin
          dd = (d_pl[i] < 0) ? 0 : d_pl[i];
          rdy[i] = r + dd;
          if (d_pl[i] >= 0) rise[i] = rdy[i];
          if (i == STG - 1) fin = rdy[i] + SG + 1;
          else r = rdy[i] + SG + 2;
        end
      end
    end
    case (mode)
      2: begin
        x = fin - 1;
        nk = 1;
      end
      3: begin
        x = s + int'($urandom_range(0, fin - 1 - s));
        nk = 1;
      end
      4: begin
        x = rdy[kk] + 1 + int'($urandom_range(0, SG - 1));
        nk = 2;
      end
      default: ;
    endcase
    lim = x;
    sr = 3'b111;
    for (int i = 0; i < nrel; i++) begin
      sr[i] = 1'b0;
      expect_at(rel[i], {sr, 3'b010, 2'b00});
    end
    if (flt) begin
      expect_at(fin, {sr, 3'b001, 2'(fstg)});
    end else begin
      expect_at(fin, {3'b000, 3'b100, 2'b00});
      if (dmask != 0 && x == BIG) begin
        dd = fin + int'($urandom_range(0, 4));
        low = 0;
        for (int i = STG - 1; i >= 0; i--) begin
          if (dmask[i]) begin
            drop[i] = dd;
            low = i;
          end
        end
        fin = dd + 1;
        expect_at(fin, {3'b000, 3'b001, 2'(low)});
      end
    end
    if (x != BIG) e = x;
    else e = fin + int'($urandom_range(2, 6));
    while (cyc < e) begin
      drive_cycle();
      tick();
    end
  endtask

  logic [7:0] prev;
  logic [7:0] mv;
  bit         seen = 0;
  ev_t        ev;

  always @(negedge Clock) begin
    mv = outv();
    if (!seen) begin
      seen = 1;
      checks++;
      if (mv !== RSTV) begin
        errors++;
        $display("FAIL reset_state got=%b want=%b", mv, RSTV);
      end
    end else if (mv !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected got=%b@%0d want=none", mv, cyc);
      end else begin
        ev = exp_q.pop_front();
        if (ev.c != cyc || ev.v !== mv) begin
          errors++;
          $display("FAIL event got=%b@%0d want=%b@%0d", mv, cyc, ev.v, ev.c);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      checks++;
      errors++;
      ev = exp_q.pop_front();
      $display("FAIL missed got=%b@%0d want=%b@%0d", mv, cyc, ev.v, ev.c);
    end
    prev = mv;
  end

  initial begin
    int  nk, mode, kk, dm, rrl, p;
    bit  por;
    #1 Reset_n = 1'b0;
    repeat (3) tick();
    nk = 2;
    for (int r = 0; r < 60; r++) begin
      kk = 0;
      dm = 0;
      mode = 0;
      if (r < 6) begin
        for (int i = 0; i < STG; i++) d_pl[i] = 3;
        case (r)
          0: dm = 4;
          1: d_pl[1] = 1000;
          3: begin
            for (int i = 0; i < STG; i++) d_pl[i] = -1;
            dm = 3;
          end
          4: begin
            d_pl[1] = 1000;
            mode = 2;
          end
          5: begin
            mode = 4;
            kk = 1;
          end
          default: ;
        endcase
      end else begin
        p = int'($urandom_range(0, 5));
        mode = (p < 3) ? 0 : (p == 3) ? 2 : (p == 4) ? 3 : 4;
        for (int i = 0; i < STG; i++) begin
          p = int'($urandom_range(0, 15));
          if (p < 3) d_pl[i] = -1;
          else if (p == 3) d_pl[i] = TO;
          else if (p == 4) d_pl[i] = TO + 1;
          else if (p == 5) d_pl[i] = 1000;
          else d_pl[i] = int'($urandom_range(0, 6));
        end
        kk = int'($urandom_range(0, STG - 1));
        if (mode == 2) begin
          d_pl[kk] = 1000;
          for (int i = 0; i < kk; i++)
            if (d_pl[i] > TO) d_pl[i] = 2;
        end
        if (mode == 4) begin
          for (int i = 0; i < STG; i++)
            if (d_pl[i] > TO) d_pl[i] = 1;
        end
        if ($urandom_range(0, 2) == 0) dm = int'($urandom_range(1, 7));
      end
      por = (nk == 2) || (nk == 0 && r != 1 && r != 2 &&
                          $urandom_range(0, 2) == 0);
      rrl = (nk == 1 || r < 6) ? 1 : int'($urandom_range(1, 3));
      run(por, rrl, mode, kk, dm, nk);
    end
    repeat (5) tick();
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      ev = exp_q.pop_front();
      $display("FAIL leftover got=none want=%b@%0d", ev.v, ev.c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=cycle %0d want=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
